// File: rtl/usb_cmd_pkg.sv
// Shared types and constants for the FT232H command receive path.
// Optional feature macro: USB_RX_TIMEOUT_EN (partial-frame idle timeout).
package usb_cmd_pkg;

  // Bus-side FSM for the synchronous FIFO read handshake
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OE_WAIT = 2'd1,
    READ    = 2'd2
  } bus_state_t;

  // Frame parser: sync marker, command ID, value, checksum
  typedef enum logic [1:0] {
    P_SYNC = 2'd0,
    P_CMD  = 2'd1,
    P_VAL  = 2'd2,
    P_CHK  = 2'd3
  } parser_state_t;

  // Command IDs ('V', 'T', 'R', 'S')
  localparam logic [7:0] CMD_V = 8'h56;
  localparam logic [7:0] CMD_T = 8'h54;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_S = 8'h53;

  // Default frame start marker ('$')
  localparam logic [7:0] SYNC_BYTE_DEF = 8'h24;

  // Frame checksum: command XOR value
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] val);
    return cmd ^ val;
  endfunction

endpackage

// File: rtl/usb_cmd_receiver_if.sv
// FT232H synchronous FIFO read-direction bus.
// master: FPGA side (drives oe/rd). slave: FT232H side (drives data/rxf).
interface usb_cmd_receiver_if;
  logic [7:0] data_in;
  logic       rxf;
  logic       oe;
  logic       rd;

  modport master (input data_in, input rxf, output oe, output rd);
  modport slave  (output data_in, output rxf, input oe, input rd);
endinterface

// File: rtl/usb_cmd_parser.sv
// Command frame parser: SYNC, CMD, VAL, CHK. Holds the host-override settings.
// With USB_RX_TIMEOUT_EN defined, a partial frame idle for TIMEOUT_CYCLES is
// abandoned with a cmd_err pulse; otherwise it waits indefinitely.
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0]  V_SCALE_RST    = 8'h30,
  parameter logic [7:0]  T_SCALE_RST    = 8'h30,
  parameter logic [7:0]  TRIG_RST       = 8'h30,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic [7:0] v_scale,
  output logic [7:0] t_scale,
  output logic [7:0] trigger_level,
  output logic       ch_select,
  output logic       cmd_valid,
  output logic       cmd_err
);

  // The idle counter is 16 bits wide, so the threshold must fit in it
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("usb_cmd_parser: TIMEOUT_CYCLES must be in 1..65535");
  end

  parser_state_t p_state, p_next;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] val_q, val_d;
  logic [7:0] v_d, t_d, trig_d;
  logic       ch_d, valid_d, err_d;

`ifdef USB_RX_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout;

  assign timeout = (idle_cnt == 16'(TIMEOUT_CYCLES));

  // Idle counter: runs only while a frame is partially received
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (byte_vld || p_state == P_SYNC || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end
`endif

  // Next-state, field capture and frame outcome
  always_comb begin
    p_next  = p_state;
    cmd_d   = cmd_q;
    val_d   = val_q;
    v_d     = v_scale;
    t_d     = t_scale;
    trig_d  = trigger_level;
    ch_d    = ch_select;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (byte_vld) begin
      unique case (p_state)
        P_SYNC: if (byte_in == SYNC_BYTE) p_next = P_CMD;
        P_CMD: begin
          cmd_d  = byte_in;
          p_next = P_VAL;
        end
        P_VAL: begin
          val_d  = byte_in;
          p_next = P_CHK;
        end
        P_CHK: begin
          p_next = P_SYNC;
          if (byte_in == frame_chk(cmd_q, val_q)) begin
            unique case (cmd_q)
              CMD_V: begin v_d    = val_q;    valid_d = 1'b1; end
              CMD_T: begin t_d    = val_q;    valid_d = 1'b1; end
              CMD_R: begin trig_d = val_q;    valid_d = 1'b1; end
              CMD_S: begin ch_d   = val_q[0]; valid_d = 1'b1; end
              default: err_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        default: p_next = P_SYNC;
      endcase
    end
`ifdef USB_RX_TIMEOUT_EN
    else if (timeout) begin
      p_next = P_SYNC;
      err_d  = 1'b1;
    end
`endif
  end

  // Parser state and settings registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state       <= P_SYNC;
      cmd_q         <= '0;
      val_q         <= '0;
      v_scale       <= V_SCALE_RST;
      t_scale       <= T_SCALE_RST;
      trigger_level <= TRIG_RST;
      ch_select     <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      p_state       <= p_next;
      cmd_q         <= cmd_d;
      val_q         <= val_d;
      v_scale       <= v_d;
      t_scale       <= t_d;
      trigger_level <= trig_d;
      ch_select     <= ch_d;
      cmd_valid     <= valid_d;
      cmd_err       <= err_d;
    end
  end

endmodule

// File: rtl/usb_cmd_receiver.sv
// FT232H receive path: synchronous FIFO read handshake (RXF#, OE#, RD#),
// byte capture, and command frame parsing into host-override settings.
// Optional feature macro: USB_RX_TIMEOUT_EN (see usb_cmd_parser).
module usb_cmd_receiver
  import usb_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0]  V_SCALE_RST    = 8'h30,
  parameter logic [7:0]  T_SCALE_RST    = 8'h30,
  parameter logic [7:0]  TRIG_RST       = 8'h30,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  usb_cmd_receiver_if.master    bus,
  output logic [7:0]            v_scale,
  output logic [7:0]            t_scale,
  output logic [7:0]            trigger_level,
  output logic                  ch_select,
  output logic                  cmd_valid,
  output logic                  cmd_err
);

  bus_state_t state_q, state_d;
  logic       oe_q, rd_q;
  logic [7:0] byte_q;
  logic       byte_vld;

  // Bus state register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Bus next-state: one OE-only cycle before reading, stop as soon as RXF# rises
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.rxf) state_d = OE_WAIT;
      OE_WAIT: state_d = bus.rxf ? IDLE : READ;
      READ:    if (bus.rxf) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // oe/rd registered from the next state so they track the FSM without a lag
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      oe_q <= 1'b1;
      rd_q <= 1'b1;
    end else begin
      oe_q <= !(state_d == OE_WAIT || state_d == READ);
      rd_q <= !(state_d == READ);
    end
  end

  assign bus.oe = oe_q;
  assign bus.rd = rd_q;

  // Byte capture: one byte per edge where the FT232H actually advanced its FIFO
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      byte_q   <= '0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= !rd_q && !oe_q && !bus.rxf;
      if (!rd_q && !oe_q && !bus.rxf) byte_q <= bus.data_in;
    end
  end

  usb_cmd_parser #(
    .SYNC_BYTE      (SYNC_BYTE),
    .V_SCALE_RST    (V_SCALE_RST),
    .T_SCALE_RST    (T_SCALE_RST),
    .TRIG_RST       (TRIG_RST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_parser (
    .clk           (clk_in),
    .rst_n         (reset_n),
    .byte_in       (byte_q),
    .byte_vld      (byte_vld),
    .v_scale       (v_scale),
    .t_scale       (t_scale),
    .trigger_level (trigger_level),
    .ch_select     (ch_select),
    .cmd_valid     (cmd_valid),
    .cmd_err       (cmd_err)
  );

endmodule

// File: tb/tb_usb_cmd_receiver.sv
// Directed testbench for usb_cmd_receiver: the bench plays the FT232H side.
module tb_usb_cmd_receiver;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic [7:0] v_scale, t_scale, trigger_level;
  logic       ch_select, cmd_valid, cmd_err;

  usb_cmd_receiver_if bus ();

  usb_cmd_receiver dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .bus           (bus),
    .v_scale       (v_scale),
    .t_scale       (t_scale),
    .trigger_level (trigger_level),
    .ch_select     (ch_select),
    .cmd_valid     (cmd_valid),
    .cmd_err       (cmd_err)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Event monitor, sampled away from the active edge
  int   n_valid = 0, n_err = 0, n_cap = 0, n_oe_fall = 0, cyc = 0;
  int   oe_fall_cyc = 0, rd_fall_cyc = 0;
  bit   overlap = 1'b0;
  logic prev_oe = 1'b1, prev_rd = 1'b1;
  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (cmd_valid === 1'b1) n_valid <= n_valid + 1;
    if (cmd_err === 1'b1) n_err <= n_err + 1;
    if (cmd_valid === 1'b1 && cmd_err === 1'b1) overlap <= 1'b1;
    if (dut.byte_vld === 1'b1) n_cap <= n_cap + 1;
    if (prev_oe === 1'b1 && bus.oe === 1'b0) begin
      n_oe_fall <= n_oe_fall + 1;
      oe_fall_cyc <= cyc;
    end
    if (prev_rd === 1'b1 && bus.rd === 1'b0) rd_fall_cyc <= cyc;
    prev_oe <= bus.oe;
    prev_rd <= bus.rd;
  end

  logic [7:0] tx [0:15];
  int v0, e0, c0, f0;

  task automatic set4(input int at, input logic [7:0] a, b, c, d);
    tx[at] = a; tx[at+1] = b; tx[at+2] = c; tx[at+3] = d;
  endtask

  task automatic snap();
    v0 = n_valid; e0 = n_err; c0 = n_cap; f0 = n_oe_fall;
  endtask

  // Present tx[0..n-1] as FIFO contents; optional RXF# gap before byte gap_at.
  // Ends at the negedge after the last byte was taken, with rxf released.
  task automatic send(input int n, input int gap_at, input int gap_len);
    int idx = 0, g = 0, budget = 200;
    bit will;
    while (idx < n && budget > 0) begin
      @(negedge clk_in);
      bus.data_in = tx[idx];
      if (idx == gap_at && g < gap_len) begin
        bus.rxf = 1'b1; g++;
      end else begin
        bus.rxf = 1'b0;
      end
      will = !bus.rd && !bus.oe && !bus.rxf;
      @(posedge clk_in);
      if (will) idx++;
      budget--;
    end
    vectors++;
    if (idx != n) begin
      $display("FAIL send_budget: took %0d bytes, required %0d", idx, n);
      miscompares++;
    end
    @(negedge clk_in);
    bus.rxf = 1'b1;
  endtask

  task automatic test_reset();
    vectors += 8;
    if (bus.oe !== 1'b1) begin $display("FAIL rst_oe: got %b want 1", bus.oe); miscompares++; end
    if (bus.rd !== 1'b1) begin $display("FAIL rst_rd: got %b want 1", bus.rd); miscompares++; end
    if (v_scale !== 8'h30) begin $display("FAIL rst_v: got %h want 30", v_scale); miscompares++; end
    if (t_scale !== 8'h30) begin $display("FAIL rst_t: got %h want 30", t_scale); miscompares++; end
    if (trigger_level !== 8'h30) begin $display("FAIL rst_trig: got %h want 30", trigger_level); miscompares++; end
    if (ch_select !== 1'b0) begin $display("FAIL rst_ch: got %b want 0", ch_select); miscompares++; end
    if (cmd_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", cmd_valid); miscompares++; end
    if (cmd_err !== 1'b0) begin $display("FAIL rst_err: got %b want 0", cmd_err); miscompares++; end
  endtask

  task automatic test_v_frame();
    snap();
    set4(0, 8'h24, 8'h56, 8'h7A, 8'h2C);
    send(4, -1, 0);
    vectors += 2;
    if (cmd_valid !== 1'b0) begin $display("FAIL v_early_valid: got %b want 0", cmd_valid); miscompares++; end
    if (v_scale !== 8'h30) begin $display("FAIL v_early_reg: got %h want 30", v_scale); miscompares++; end
    @(negedge clk_in);
    vectors += 2;
    if (cmd_valid !== 1'b1) begin $display("FAIL v_lat_valid: got %b want 1", cmd_valid); miscompares++; end
    if (v_scale !== 8'h7A) begin $display("FAIL v_lat_reg: got %h want 7a", v_scale); miscompares++; end
    repeat (4) @(negedge clk_in);
    vectors += 4;
    if (rd_fall_cyc - oe_fall_cyc != 1) begin $display("FAIL v_oe_rd_gap: got %0d want 1", rd_fall_cyc - oe_fall_cyc); miscompares++; end
    if (n_cap - c0 != 4) begin $display("FAIL v_caps: got %0d want 4", n_cap - c0); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL v_valid_cnt: got %0d want 1", n_valid - v0); miscompares++; end
    if (n_err - e0 != 0) begin $display("FAIL v_err_cnt: got %0d want 0", n_err - e0); miscompares++; end
    vectors += 2;
    if (bus.oe !== 1'b1) begin $display("FAIL v_oe_idle: got %b want 1", bus.oe); miscompares++; end
    if (bus.rd !== 1'b1) begin $display("FAIL v_rd_idle: got %b want 1", bus.rd); miscompares++; end
  endtask

  task automatic test_bad_checksum();
    snap();
    set4(0, 8'h24, 8'h54, 8'h10, 8'h45);
    send(4, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 3;
    if (n_err - e0 != 1) begin $display("FAIL chk_err_cnt: got %0d want 1", n_err - e0); miscompares++; end
    if (n_valid - v0 != 0) begin $display("FAIL chk_valid_cnt: got %0d want 0", n_valid - v0); miscompares++; end
    if (t_scale !== 8'h30) begin $display("FAIL chk_t: got %h want 30", t_scale); miscompares++; end
  endtask

  task automatic test_rxf_gap();
    snap();
    set4(0, 8'h24, 8'h52, 8'h99, 8'hCB);
    send(4, 2, 3);
    repeat (4) @(negedge clk_in);
    vectors += 4;
    if (trigger_level !== 8'h99) begin $display("FAIL gap_trig: got %h want 99", trigger_level); miscompares++; end
    if (n_cap - c0 != 4) begin $display("FAIL gap_caps: got %0d want 4", n_cap - c0); miscompares++; end
    if (n_oe_fall - f0 != 2) begin $display("FAIL gap_oe_falls: got %0d want 2", n_oe_fall - f0); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL gap_valid_cnt: got %0d want 1", n_valid - v0); miscompares++; end
  endtask

  task automatic test_garbage();
    snap();
    tx[0] = 8'h00; tx[1] = 8'hFF;
    set4(2, 8'h24, 8'h53, 8'h01, 8'h52);
    set4(6, 8'h24, 8'h41, 8'h05, 8'h44);
    send(10, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 4;
    if (ch_select !== 1'b1) begin $display("FAIL gb_ch: got %b want 1", ch_select); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL gb_valid_cnt: got %0d want 1", n_valid - v0); miscompares++; end
    if (n_err - e0 != 1) begin $display("FAIL gb_err_cnt: got %0d want 1", n_err - e0); miscompares++; end
    if (n_cap - c0 != 10) begin $display("FAIL gb_caps: got %0d want 10", n_cap - c0); miscompares++; end
  endtask

  task automatic test_back_to_back();
    snap();
    set4(0, 8'h24, 8'h56, 8'h11, 8'h47);
    set4(4, 8'h24, 8'h54, 8'h20, 8'h74);
    send(8, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 4;
    if (v_scale !== 8'h11) begin $display("FAIL b2b_v: got %h want 11", v_scale); miscompares++; end
    if (t_scale !== 8'h20) begin $display("FAIL b2b_t: got %h want 20", t_scale); miscompares++; end
    if (n_valid - v0 != 2) begin $display("FAIL b2b_valid_cnt: got %0d want 2", n_valid - v0); miscompares++; end
    if (n_oe_fall - f0 != 1) begin $display("FAIL b2b_oe_falls: got %0d want 1", n_oe_fall - f0); miscompares++; end
  endtask

  task automatic test_mid_frame_reset();
    set4(0, 8'h24, 8'h56, 8'h00, 8'h00);
    send(2, -1, 0);
    #1 reset_n = 1'b0;
    #1;
    vectors += 5;
    if (bus.oe !== 1'b1) begin $display("FAIL mrst_oe: got %b want 1", bus.oe); miscompares++; end
    if (bus.rd !== 1'b1) begin $display("FAIL mrst_rd: got %b want 1", bus.rd); miscompares++; end
    if (v_scale !== 8'h30) begin $display("FAIL mrst_v: got %h want 30", v_scale); miscompares++; end
    if (t_scale !== 8'h30) begin $display("FAIL mrst_t: got %h want 30", t_scale); miscompares++; end
    if (ch_select !== 1'b0) begin $display("FAIL mrst_ch: got %b want 0", ch_select); miscompares++; end
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);
    snap();
    set4(0, 8'h24, 8'h56, 8'h11, 8'h47);
    send(4, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 3;
    if (v_scale !== 8'h11) begin $display("FAIL mrst_next_v: got %h want 11", v_scale); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL mrst_valid_cnt: got %0d want 1", n_valid - v0); miscompares++; end
    if (n_err - e0 != 0) begin $display("FAIL mrst_err_cnt: got %0d want 0", n_err - e0); miscompares++; end
  endtask

  // Partial frame resumed after a short idle completes normally
  task automatic test_partial_wait();
    snap();
    set4(0, 8'h24, 8'h56, 8'h22, 8'h74);
    send(2, -1, 0);
    repeat (200) @(negedge clk_in);
    tx[0] = 8'h22; tx[1] = 8'h74;
    send(2, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 3;
    if (v_scale !== 8'h22) begin $display("FAIL wait_v: got %h want 22", v_scale); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL wait_valid_cnt: got %0d want 1", n_valid - v0); miscompares++; end
    if (n_err - e0 != 0) begin $display("FAIL wait_err_cnt: got %0d want 0", n_err - e0); miscompares++; end
  endtask

`ifdef USB_RX_TIMEOUT_EN
  task automatic test_timeout();
    snap();
    set4(0, 8'h24, 8'h56, 8'h00, 8'h00);
    send(2, -1, 0);
    repeat (60100) @(negedge clk_in);
    vectors += 2;
    if (n_err - e0 != 1) begin $display("FAIL to_err_cnt: got %0d want 1", n_err - e0); miscompares++; end
    if (n_valid - v0 != 0) begin $display("FAIL to_valid_cnt: got %0d want 0", n_valid - v0); miscompares++; end
    set4(0, 8'h24, 8'h56, 8'h22, 8'h74);
    send(4, -1, 0);
    repeat (4) @(negedge clk_in);
    vectors += 2;
    if (v_scale !== 8'h22) begin $display("FAIL to_next_v: got %h want 22", v_scale); miscompares++; end
    if (n_valid - v0 != 1) begin $display("FAIL to_next_valid: got %0d want 1", n_valid - v0); miscompares++; end
  endtask
`endif

  task automatic test_exclusive();
    vectors++;
    if (overlap !== 1'b0) begin $display("FAIL valid_err_overlap: got %b want 0", overlap); miscompares++; end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.rxf     = 1'b1;
    bus.data_in = 8'h00;
    repeat (3) @(negedge clk_in);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);
    test_v_frame();
    test_bad_checksum();
    test_rxf_gap();
    test_garbage();
    test_back_to_back();
    test_mid_frame_reset();
    test_partial_wait();
`ifdef USB_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_cmd_receiver.md
Name: usb_cmd_receiver

Overview:
- Receive-side counterpart of the FPGA-to-FT232H transmit path.
- Reads bytes the host PC writes into the FT232H receive FIFO, using the 60 MHz synchronous FIFO read handshake (RXF#, OE#, RD#).
- Parses the bytes into fixed 4-byte command frames.
- Holds the decoded settings (volt scale, time scale, trigger level, channel select) so the host can override the front-panel knobs.

Parameters:
- SYNC_BYTE, 8'h24, frame start marker ('$').
- V_SCALE_RST, 8'h30, reset value of v_scale.
- T_SCALE_RST, 8'h30, reset value of t_scale.
- TRIG_RST, 8'h30, reset value of trigger_level.
- TIMEOUT_CYCLES, 60000, idle cycles before the parser abandons a partial frame (used only with the optional feature).

Ports:
- clk_in  input  1  60 MHz clock from the FT232H board.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  8  FT232H data bus, read direction.
- rxf  input  1  active low; receive FIFO holds at least one byte.
- oe  output  1  active low; FT232H drives the bus.
- rd  output  1  active low; FT232H advances its FIFO each clock.
- v_scale  output  8  last accepted 'V' value.
- t_scale  output  8  last accepted 'T' value.
- trigger_level  output  8  last accepted 'R' value.
- ch_select  output  1  last accepted 'S' value, bit 0.
- cmd_valid  output  1  one-cycle pulse when a frame is accepted.
- cmd_err  output  1  one-cycle pulse on checksum or command-ID error.

Behaviour:
- Reset (async, reset_n low):
  - oe=1, rd=1.
  - Settings outputs take their *_RST values; ch_select=0.
  - cmd_valid=0, cmd_err=0.
  - Bus FSM goes to IDLE; parser goes to P_SYNC.
- Reset mid-frame discards the partial frame. Reset mid-burst releases oe and rd immediately (asynchronously).
- Bus FSM, all outputs registered:
  - IDLE: oe=1, rd=1. Go to OE_WAIT when rxf is sampled 0.
  - OE_WAIT: oe=0, rd=1, for exactly one cycle. Go to READ if rxf=0, otherwise IDLE.
  - READ: oe=0, rd=0. Stay while rxf=0. When rxf is sampled 1, go to IDLE; oe and rd deassert on the next edge.
- Byte capture: a byte is captured at a rising edge only when the registered rd=0 and oe=0 and the sampled rxf=0.
  - Exactly one byte per such edge; continuous bursts run at 1 byte per clock.
  - No byte is captured at the edge where rxf is high, so bytes are neither duplicated nor dropped across RXF# gaps.
- Parser, advanced by captured bytes only:
  - P_SYNC: on SYNC_BYTE go to P_CMD; any other byte is silently discarded.
  - P_CMD: store the byte as cmd, go to P_VAL.
  - P_VAL: store the byte as val, go to P_CHK.
  - P_CHK: the byte must equal cmd XOR val. Always return to P_SYNC.
- Frame outcome:
  - Checksum good and cmd in {'V','T','R','S'}: update the matching setting register and pulse cmd_valid on the same edge. For 'S', ch_select=val[0].
  - Checksum bad or cmd unknown: pulse cmd_err. No register changes.
- Latency: cmd_valid and the register update appear 1 cycle after the capture edge of the checksum byte.
- A SYNC_BYTE value in P_CMD, P_VAL or P_CHK is treated as data; there is no resynchronisation inside a frame.
- cmd_valid and cmd_err are never high together.
- Back-to-back frames in one burst are parsed with no gap cycles.

Optional Feature:
- Macro USB_RX_TIMEOUT_EN.
- Defined: a 16-bit idle counter clears on each captured byte and increments while the parser is not in P_SYNC. On reaching TIMEOUT_CYCLES the parser returns to P_SYNC and pulses cmd_err for one cycle.
- Not defined: no counter; a partial frame waits indefinitely for its next byte.

Decomposition:
- Package usb_cmd_pkg:
  - Bus-state and parser-state enums.
  - Command-ID constants: CMD_V=8'h56, CMD_T=8'h54, CMD_R=8'h52, CMD_S=8'h53.
  - Default SYNC_BYTE.
- Sub-module usb_cmd_parser: takes a byte plus byte-valid strobe and holds the parser FSM, checksum check, setting registers and optional timeout.
- The top level holds the bus FSM and the capture logic.

Test Plan:
- rxf held 0 with bytes 24 56 7A 2C -> oe falls, rd falls 1 cycle later, 4 captures, then v_scale=8'h7A and one cmd_valid pulse.
- Frame 24 54 10 45 (bad checksum, 54^10=44) -> one cmd_err pulse; t_scale remains 8'h30.
- rxf deasserts for 3 cycles between bytes 52 and 99 of frame 24 52 99 CB -> bus returns to IDLE then OE_WAIT; trigger_level=8'h99; no duplicate capture.
- Garbage 00 FF 24 53 01 52 followed by 24 41 05 44 -> ch_select=1 with one cmd_valid; unknown 'A' gives one cmd_err.
- reset_n pulsed low after 24 56 -> oe and rd go 1 immediately and registers return to reset values; next frame 24 56 11 47 sets v_scale=8'h11.
- With USB_RX_TIMEOUT_EN, send 24 56 then idle 60000 cycles -> cmd_err pulse; then 24 56 22 74 sets v_scale=8'h22.
